// File: rtl/scoreboard_ctrl_multi.sv
// scoreboard_ctrl_multi: multi-level basketball scoreboard controller.
// Keeps a BCD score with saturation and a BCD countdown timer driven by an internal seconds tick.
// A basket is worth 3 points in the bonus window and 2 otherwise. The controller moves through
// the game levels, reports won/done at the end, and drives 7-segment codes for score, timer and level.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start, shot, pause      level inputs; start/shot act on their rising edge
//   score_bcd, timer_bcd    BCD score (digit 0 = units in [3:0]) and seconds remaining
//   level, state            current level (1..NUM_LEVELS), FSM state code
//   done, won               game finished / final level passed
//   seg_score, seg_timer,
//   seg_level               active-high {g,f,e,d,c,b,a} segment codes of the values above
module scoreboard_ctrl_multi #(
    parameter int unsigned SCORE_DIGITS = 3,
    parameter int unsigned TIME_SEC     = 60,
    parameter int unsigned BONUS_SEC    = 15,
    parameter int unsigned NUM_LEVELS   = 2,
    parameter int unsigned THRESHOLD    = 40,
    parameter int unsigned THRESH_STEP  = 20,
    parameter int unsigned TICK_DIV     = 50000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      shot,
    input  logic                      pause,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [7:0]                timer_bcd,
    output logic [3:0]                level,
    output logic [2:0]                state,
    output logic                      done,
    output logic                      won,
    output logic [7*SCORE_DIGITS-1:0] seg_score,
    output logic [13:0]               seg_timer,
    output logic [6:0]                seg_level
);

    localparam int unsigned     SW        = 4 * SCORE_DIGITS;
    localparam int unsigned     GW        = 7 * SCORE_DIGITS;
    localparam int unsigned     CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0]      TIME_INIT = {4'(TIME_SEC / 10), 4'(TIME_SEC % 10)};
    localparam logic [SW-1:0]   SCORE_MAX = {SCORE_DIGITS{4'h9}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_EVAL  = 3'd3,
        S_LVLUP = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    score_q, score_d;
    logic [7:0]       timer_q, timer_d;
    logic [3:0]       level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             won_q, won_d;
    logic             done_q;
    logic             start_q, shot_q;
    logic [GW-1:0]    seg_score_q, seg_score_d;
    logic [13:0]      seg_timer_q;
    logic [6:0]       seg_level_q;

    logic             start_edge, shot_edge, tick, bonus;
    logic [7:0]       timer_dec;
    logic [6:0]       timer_bin;
    logic [31:0]      score_bin, thresh;

    // Digit to active-high {g,f,e,d,c,b,a}; non-decimal codes blank the digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // BCD add of a small increment with ripple carry; overflow clamps to all nines
    function automatic logic [SW-1:0] bcd_add(input logic [SW-1:0] s, input logic [3:0] inc);
        logic [SW-1:0] r;
        logic [4:0]    sum;
        logic [3:0]    c;
        r = s;
        c = inc;
        for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
            sum = 5'(s[4*i +: 4]) + 5'(c);
            if (sum >= 5'd10) begin
                r[4*i +: 4] = 4'(sum - 5'd10);
                c           = 4'd1;
            end else begin
                r[4*i +: 4] = sum[3:0];
                c           = 4'd0;
            end
        end
        if (c != 4'd0) r = SCORE_MAX;
        return r;
    endfunction

    assign start_edge = start & ~start_q;
    assign shot_edge  = shot & ~shot_q;
    assign tick       = (cnt_q == CNT_MAX);
    assign timer_dec  = (timer_q[3:0] == 4'd0) ? {timer_q[7:4] - 4'd1, 4'd9}
                                               : {timer_q[7:4], timer_q[3:0] - 4'd1};
    assign timer_bin  = 7'(timer_q[7:4]) * 7'd10 + 7'(timer_q[3:0]);
    // Bonus uses the timer value before any decrement in the same cycle
    assign bonus      = (32'(timer_bin) <= BONUS_SEC);
    assign thresh     = 32'(THRESHOLD) + 32'(level_q - 4'd1) * 32'(THRESH_STEP);

    // Decoded binary score for the level threshold compare
    always_comb begin
        logic [31:0] w;
        score_bin = '0;
        w         = 32'd1;
        for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
            score_bin = score_bin + 32'(score_q[4*i +: 4]) * w;
            w         = w * 32'd10;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        timer_d = timer_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        won_d   = won_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) state_d = S_LOAD;
            end
            S_LOAD: begin
                score_d = '0;
                level_d = 4'd1;
                timer_d = TIME_INIT;
                cnt_d   = '0;
                won_d   = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!pause) begin
                    if (shot_edge) score_d = bcd_add(score_q, bonus ? 4'd3 : 4'd2);
                    if (tick) begin
                        cnt_d   = '0;
                        timer_d = timer_dec;
                        if (timer_dec == 8'h00) state_d = S_EVAL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_EVAL: begin
                if (score_bin >= thresh) begin
                    if (level_q < 4'(NUM_LEVELS)) begin
                        state_d = S_LVLUP;
                    end else begin
                        state_d = S_DONE;
                        won_d   = 1'b1;
                    end
                end else begin
                    state_d = S_DONE;
                    won_d   = 1'b0;
                end
            end
            S_LVLUP: begin
                level_d = level_q + 4'd1;
                timer_d = TIME_INIT;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Segment codes follow the next-state values so they register alongside them
    always_comb begin
        seg_score_d = '0;
        for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
            seg_score_d[7*i +: 7] = seg7(score_d[4*i +: 4]);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            score_q     <= '0;
            timer_q     <= TIME_INIT;
            level_q     <= 4'd1;
            cnt_q       <= '0;
            won_q       <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            shot_q      <= 1'b0;
            seg_score_q <= {SCORE_DIGITS{7'h3F}};
            seg_timer_q <= {seg7(TIME_INIT[7:4]), seg7(TIME_INIT[3:0])};
            seg_level_q <= 7'h06;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            timer_q     <= timer_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            won_q       <= won_d;
            done_q      <= (state_d == S_DONE);
            start_q     <= start;
            shot_q      <= shot;
            seg_score_q <= seg_score_d;
            seg_timer_q <= {seg7(timer_d[7:4]), seg7(timer_d[3:0])};
            seg_level_q <= seg7(level_d);
        end
    end

    assign score_bcd = score_q;
    assign timer_bcd = timer_q;
    assign level     = level_q;
    assign state     = state_q;
    assign done      = done_q;
    assign won       = won_q;
    assign seg_score = seg_score_q;
    assign seg_timer = seg_timer_q;
    assign seg_level = seg_level_q;

endmodule

// File: tb/tb_scoreboard_ctrl_multi.sv
// Testbench for scoreboard_ctrl_multi: a game-rule model runs beside the DUT and is compared
// every cycle, with literal expectations at key points of several directed games.
module tb_scoreboard_ctrl_multi;

    localparam int SD   = 3;
    localparam int TS   = 99;
    localparam int BS   = 15;
    localparam int NL   = 2;
    localparam int TH   = 40;
    localparam int TST  = 20;
    localparam int TD   = 16;
    localparam int SMAX = 999;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          shot = 1'b0;
    logic          pause = 1'b0;
    logic [11:0]   score_bcd;
    logic [7:0]    timer_bcd;
    logic [3:0]    level;
    logic [2:0]    state;
    logic          done;
    logic          won;
    logic [20:0]   seg_score;
    logic [13:0]   seg_timer;
    logic [6:0]    seg_level;

    scoreboard_ctrl_multi #(
        .SCORE_DIGITS(SD), .TIME_SEC(TS), .BONUS_SEC(BS), .NUM_LEVELS(NL),
        .THRESHOLD(TH), .THRESH_STEP(TST), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .shot(shot), .pause(pause),
        .score_bcd(score_bcd), .timer_bcd(timer_bcd), .level(level), .state(state),
        .done(done), .won(won), .seg_score(seg_score), .seg_timer(seg_timer),
        .seg_level(seg_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- game-rule model ----------------
    typedef struct {
        int st;
        int score;
        int timer;
        int level;
        int cnt;
        bit won;
        bit sp;
        bit hp;
    } model_t;

    model_t m;
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic model_t model_reset();
        model_t r;
        r.st = 0; r.score = 0; r.timer = TS; r.level = 1; r.cnt = 0;
        r.won = 1'b0; r.sp = 1'b0; r.hp = 1'b0;
        return r;
    endfunction

    function automatic model_t model_next(input model_t c, input bit st_i, input bit sh_i, input bit pz);
        model_t n;
        bit se, he;
        int pts, thr;
        n = c;
        n.sp = st_i;
        n.hp = sh_i;
        se = st_i && !c.sp;
        he = sh_i && !c.hp;
        case (c.st)
            0, 5: if (se) n.st = 1;
            1: begin
                n.score = 0; n.level = 1; n.timer = TS; n.cnt = 0; n.won = 1'b0; n.st = 2;
            end
            2: if (!pz) begin
                if (he) begin
                    pts = (c.timer <= BS) ? 3 : 2;
                    n.score = (c.score + pts > SMAX) ? SMAX : c.score + pts;
                end
                if (c.cnt == TD - 1) begin
                    n.cnt = 0;
                    n.timer = c.timer - 1;
                    if (n.timer == 0) n.st = 3;
                end else begin
                    n.cnt = c.cnt + 1;
                end
            end
            3: begin
                thr = TH + (c.level - 1) * TST;
                if (c.score >= thr) begin
                    if (c.level < NL) n.st = 4;
                    else begin n.st = 5; n.won = 1'b1; end
                end else begin
                    n.st = 5; n.won = 1'b0;
                end
            end
            4: begin
                n.level = c.level + 1; n.timer = TS; n.cnt = 0; n.st = 2;
            end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, start, shot, pause);
    end

    function automatic logic [11:0] exp_score(input int s);
        logic [11:0] r;
        int p;
        p = 1;
        for (int i = 0; i < SD; i++) begin
            r[4*i +: 4] = 4'((s / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [20:0] exp_seg_score(input int s);
        logic [20:0] r;
        int p;
        p = 1;
        for (int i = 0; i < SD; i++) begin
            r[7*i +: 7] = seg_tab[(s / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_score", 32'(score_bcd), 32'(exp_score(m.score)));
            check("cyc_timer", 32'(timer_bcd), 32'({4'(m.timer / 10), 4'(m.timer % 10)}));
            check("cyc_level", 32'(level), 32'(m.level));
            check("cyc_state", 32'(state), 32'(m.st));
            check("cyc_done", 32'(done), 32'(m.st == 5));
            check("cyc_won", 32'(won), 32'(m.won));
            check("cyc_seg_score", 32'(seg_score), 32'(exp_seg_score(m.score)));
            check("cyc_seg_timer", 32'(seg_timer), 32'({seg_tab[m.timer / 10], seg_tab[m.timer % 10]}));
            check("cyc_seg_level", 32'(seg_level), 32'(seg_tab[m.level]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_shot();
        shot = 1'b1; cyc();
        shot = 1'b0; cyc();
    endtask

    task automatic start_game();
        start = 1'b1; cyc();
        check("load_state", 32'(state), 32'd1);
        start = 1'b0; cyc();
        check("run_state", 32'(state), 32'd2);
        check("run_score", 32'(score_bcd), 32'h000);
        check("run_timer", 32'(timer_bcd), 32'h99);
        check("run_level", 32'(level), 32'd1);
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int budget);
        int k;
        k = 0;
        while (state !== s && k < budget) begin cyc(); k++; end
        check(name, 32'(state), 32'(s));
    endtask

    task automatic wait_timer(input string name, input logic [7:0] t, input int budget);
        int k;
        k = 0;
        while (timer_bcd !== t && k < budget) begin cyc(); k++; end
        check(name, 32'(timer_bcd), 32'(t));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        cmp_en = 1'b1;

        // Reset values and decoded segments
        check("rst_score", 32'(score_bcd), 32'h000);
        check("rst_timer", 32'(timer_bcd), 32'h99);
        check("rst_level", 32'(level), 32'd1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_won", 32'(won), 32'd0);
        check("rst_seg_score", 32'(seg_score), 32'({7'h3F, 7'h3F, 7'h3F}));
        check("rst_seg_timer", 32'(seg_timer), 32'({7'h6F, 7'h6F}));
        check("rst_seg_level", 32'(seg_level), 32'h06);

        // Shots ignored in IDLE
        do_shot();
        check("idle_shot", 32'(score_bcd), 32'h000);

        // Game 1: carries, saturation, win after two levels
        start_game();
        repeat (4) do_shot();
        check("g1_008", 32'(score_bcd), 32'h008);
        do_shot();
        check("g1_carry_010", 32'(score_bcd), 32'h010);
        repeat (44) do_shot();
        check("g1_098", 32'(score_bcd), 32'h098);
        do_shot();
        check("g1_carry_100", 32'(score_bcd), 32'h100);
        repeat (448) do_shot();
        check("g1_996", 32'(score_bcd), 32'h996);
        do_shot();
        check("g1_998", 32'(score_bcd), 32'h998);
        do_shot();
        check("g1_sat_999", 32'(score_bcd), 32'h999);
        do_shot();
        check("g1_sat_hold", 32'(score_bcd), 32'h999);
        wait_state("g1_lvlup", 3'd4, 2000);
        cyc();
        check("g1_lvl2_level", 32'(level), 32'd2);
        check("g1_lvl2_timer", 32'(timer_bcd), 32'h99);
        check("g1_lvl2_score", 32'(score_bcd), 32'h999);
        wait_state("g1_done", 3'd5, 2000);
        cyc();
        check("g1_done_flag", 32'(done), 32'd1);
        check("g1_won", 32'(won), 32'd1);
        do_shot();
        repeat (4) cyc();
        check("g1_frozen_score", 32'(score_bcd), 32'h999);
        check("g1_frozen_state", 32'(state), 32'd5);

        // Game 2: restart from DONE, no shots -> fail at level 1
        start_game();
        wait_state("g2_done", 3'd5, 2000);
        cyc();
        check("g2_won", 32'(won), 32'd0);
        check("g2_level", 32'(level), 32'd1);
        check("g2_done_flag", 32'(done), 32'd1);

        // Game 3: pause, mid-game start ignored, bonus boundary, fail at level 2
        start_game();
        pause = 1'b1;
        cyc();
        do_shot();
        repeat (17) cyc();
        check("g3_pause_timer", 32'(timer_bcd), 32'h99);
        check("g3_pause_score", 32'(score_bcd), 32'h000);
        pause = 1'b0;
        repeat (20) do_shot();
        check("g3_040", 32'(score_bcd), 32'h040);
        start = 1'b1; cyc();
        start = 1'b0; cyc();
        check("g3_start_ignored", 32'(state), 32'd2);
        wait_timer("g3_t16", 8'h16, 2000);
        do_shot();
        check("g3_bonus16_plus2", 32'(score_bcd), 32'h042);
        wait_timer("g3_t15", 8'h15, 2000);
        do_shot();
        check("g3_bonus15_plus3", 32'(score_bcd), 32'h045);
        wait_state("g3_lvlup", 3'd4, 2000);
        cyc();
        check("g3_lvl2", 32'(level), 32'd2);
        wait_state("g3_done", 3'd5, 2000);
        cyc();
        check("g3_won", 32'(won), 32'd0);
        check("g3_score", 32'(score_bcd), 32'h045);

        // Game 4: asynchronous reset mid-RUN
        start_game();
        repeat (6) do_shot();
        check("g4_012", 32'(score_bcd), 32'h012);
        rst_n = 1'b0;
        #1;
        check("g4_rst_score", 32'(score_bcd), 32'h000);
        check("g4_rst_timer", 32'(timer_bcd), 32'h99);
        check("g4_rst_level", 32'(level), 32'd1);
        check("g4_rst_state", 32'(state), 32'd0);
        check("g4_rst_done", 32'(done), 32'd0);
        shot = 1'b1; start = 1'b1; cyc();
        shot = 1'b0; start = 1'b0; cyc();
        cyc();
        check("g4_hold_score", 32'(score_bcd), 32'h000);
        check("g4_hold_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        cyc();
        check("g4_rel_state", 32'(state), 32'd0);
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
